// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID consumer.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t make_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr = nop;
        b.pc4   = 32'h0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; with neither asserted the contents hold.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t bundle_q;
    if_id_t bundle_d;

    always_comb begin
        bundle_d = bundle_q;
        if (bubble) begin
            bundle_d = make_bubble(NOP);
        end else if (load) begin
            bundle_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= make_bubble(NOP);
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign q = bundle_q;

endmodule

// File: rtl/if_stage.sv
// MIPS32 fetch stage: owns the PC, resolves redirects against stalls, and
// records the first misaligned redirect target.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] misalign_pc,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [31:0] mpc_q, mpc_d;
    logic [31:0] count_q, count_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        load;
    if_id_t      fetch_bundle;
    if_id_t      if_id_q;

    assign pc_plus4 = pc_q + PC_INC;

    always_comb begin
        redirect = 1'b0;
        target   = 32'h0;
        pc_d     = pc_q;
        load     = 1'b0;
        count_d  = count_q;
        err_d    = err_q;
        mpc_d    = mpc_q;

        // Branch resolves in EX for an older instruction, so it outranks a jump in ID.
        if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
        end else if (jump) begin
            redirect = 1'b1;
            target   = jump_target;
        end

        if (redirect) begin
            pc_d = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) begin
                err_d = 1'b1;
                if (!err_q) begin
                    mpc_d = target;
                end
            end
        end else if (!stall) begin
            pc_d    = pc_plus4;
            load    = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_comb begin
        fetch_bundle.instr = imem_instr;
        fetch_bundle.pc4   = pc_plus4;
        fetch_bundle.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            mpc_q   <= 32'h0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            err_q   <= err_d;
            mpc_q   <= mpc_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bubble (redirect),
        .d      (fetch_bundle),
        .q      (if_id_q)
    );

    assign imem_addr    = pc_q;
    assign if_id_instr  = if_id_q.instr;
    assign if_id_pc4    = if_id_q.pc4;
    assign if_id_valid  = if_id_q.valid;
    assign misalign_err = err_q;
    assign misalign_pc  = mpc_q;
    assign fetch_count  = count_q;

endmodule
